// File: rtl/playram_arb.sv
// Playram arbiter: video scanout owns the read port, the screen fill owns the
// write port while it runs, and the CPU is served around both.
module playram_arb #(
  parameter int ADDR_W   = 17,
  parameter int DATA_W   = 8,
  parameter int FILL_LEN = 76800
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              vid_rd_en,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_valid,
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_value,
  output logic              fill_busy,
  output logic              fill_done,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data
);

  typedef enum logic [1:0] {C_IDLE, C_RD_WAIT, C_ACK} cpu_state_e;
  typedef enum logic [1:0] {F_IDLE, F_RUN, F_DONE} fill_state_e;

  // One extra bit so a fill covering the whole address space ends without wrapping.
  localparam logic [ADDR_W:0] FillEnd = (ADDR_W+1)'(FILL_LEN);

  cpu_state_e        cpu_state_q, cpu_state_d;
  fill_state_e       fill_state_q, fill_state_d;
  logic [ADDR_W:0]   fill_cnt_q, fill_cnt_d;
  logic [DATA_W-1:0] fill_val_q, fill_val_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              vid_valid_q;
  logic              fill_busy_q, fill_busy_d;
  logic              fill_done_q, fill_done_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              cpu_wr_ok;

  assign ram_rd_addr = vid_rd_en ? vid_addr : cpu_addr;
  assign vid_rdata   = ram_rd_data;
  assign vid_valid   = vid_valid_q;
  assign cpu_ack     = cpu_ack_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign fill_busy   = fill_busy_q;
  assign fill_done   = fill_done_q;
  assign ram_wr_en   = wr_en_q;
  assign ram_wr_addr = wr_addr_q;
  assign ram_wr_data = wr_data_q;

  // A fill being accepted this cycle already blocks the CPU, so the fill wins ties.
  assign cpu_wr_ok = (fill_state_q == F_IDLE) && !fill_start;

  always_comb begin
    cpu_state_d  = cpu_state_q;
    fill_state_d = fill_state_q;
    fill_cnt_d   = fill_cnt_q;
    fill_val_d   = fill_val_q;
    cpu_ack_d    = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    fill_busy_d  = fill_busy_q;
    fill_done_d  = 1'b0;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;

    case (fill_state_q)
      F_IDLE: begin
        if (fill_start) begin
          fill_state_d = F_RUN;
          fill_val_d   = fill_value;
          fill_cnt_d   = (ADDR_W+1)'(1);
          fill_busy_d  = 1'b1;
          wr_en_d      = 1'b1;
          wr_addr_d    = '0;
          wr_data_d    = fill_value;
        end
      end
      F_RUN: begin
        if (fill_cnt_q == FillEnd) begin
          fill_state_d = F_DONE;
          fill_busy_d  = 1'b0;
          fill_done_d  = 1'b1;
        end else begin
          wr_en_d    = 1'b1;
          wr_addr_d  = fill_cnt_q[ADDR_W-1:0];
          wr_data_d  = fill_val_q;
          fill_cnt_d = fill_cnt_q + 1'b1;
        end
      end
      F_DONE: fill_state_d = F_IDLE;
      default: fill_state_d = F_IDLE;
    endcase

    case (cpu_state_q)
      C_IDLE: begin
        if (cpu_req) begin
          if (cpu_we) begin
            if (cpu_wr_ok) begin
              cpu_state_d = C_ACK;
              cpu_ack_d   = 1'b1;
              wr_en_d     = 1'b1;
              wr_addr_d   = cpu_addr;
              wr_data_d   = cpu_wdata;
            end
          end else if (!vid_rd_en) begin
            cpu_state_d = C_RD_WAIT;
          end
        end
      end
      C_RD_WAIT: begin
        cpu_state_d = C_ACK;
        cpu_ack_d   = 1'b1;
        cpu_rdata_d = ram_rd_data;
      end
      C_ACK: cpu_state_d = C_IDLE;
      default: cpu_state_d = C_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_state_q  <= C_IDLE;
      fill_state_q <= F_IDLE;
      fill_cnt_q   <= '0;
      fill_val_q   <= '0;
      cpu_ack_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      vid_valid_q  <= 1'b0;
      fill_busy_q  <= 1'b0;
      fill_done_q  <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      cpu_state_q  <= cpu_state_d;
      fill_state_q <= fill_state_d;
      fill_cnt_q   <= fill_cnt_d;
      fill_val_q   <= fill_val_d;
      cpu_ack_q    <= cpu_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      vid_valid_q  <= vid_rd_en;
      fill_busy_q  <= fill_busy_d;
      fill_done_q  <= fill_done_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

endmodule

// File: tb/tb_playram_arb.sv
// Bench for playram_arb: a transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed latencies, counts and data.
module tb_playram_arb;

  localparam int AW = 17;
  localparam int FILL_A = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0, vid_addr = '0;
  logic [7:0]    cpu_wdata = '0, fill_value = '0;
  logic          vid_rd_en = 1'b0, fill_start = 1'b0;
  logic          cpu_ack, vid_valid, fill_busy, fill_done, ram_wr_en;
  logic [7:0]    cpu_rdata, vid_rdata, ram_wr_data, ram_rd_data;
  logic [AW-1:0] ram_wr_addr, ram_rd_addr;

  playram_arb #(.ADDR_W(AW), .DATA_W(8), .FILL_LEN(FILL_A)) dutA (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .vid_rd_en(vid_rd_en), .vid_addr(vid_addr), .vid_rdata(vid_rdata), .vid_valid(vid_valid),
    .fill_start(fill_start), .fill_value(fill_value), .fill_busy(fill_busy), .fill_done(fill_done),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data));

  // Playram: write-first is not allowed, a same-edge read returns the old word.
  logic [7:0] ramA [0:(1<<AW)-1];
  always @(posedge clk) begin
    ram_rd_data <= ramA[ram_rd_addr];
    if (ram_wr_en) ramA[ram_wr_addr] <= ram_wr_data;
  end

  // Full-address-space build for the no-wrap termination case.
  logic       rstB = 1'b1, fillStartB = 1'b0, zeroBit = 1'b0;
  logic [7:0] fillValueB = '0, zeroByte = '0, cpuRdataB, vidRdataB, wrDataB;
  logic [3:0] zeroAddr = '0, wrAddrB, rdAddrB;
  logic       cpuAckB, vidValidB, fillBusyB, fillDoneB, wrEnB;

  playram_arb #(.ADDR_W(4), .DATA_W(8), .FILL_LEN(16)) dutB (
    .clk(clk), .rst(rstB), .cpu_req(zeroBit), .cpu_we(zeroBit), .cpu_addr(zeroAddr),
    .cpu_wdata(zeroByte), .cpu_ack(cpuAckB), .cpu_rdata(cpuRdataB),
    .vid_rd_en(zeroBit), .vid_addr(zeroAddr), .vid_rdata(vidRdataB), .vid_valid(vidValidB),
    .fill_start(fillStartB), .fill_value(fillValueB), .fill_busy(fillBusyB), .fill_done(fillDoneB),
    .ram_wr_en(wrEnB), .ram_wr_addr(wrAddrB), .ram_wr_data(wrDataB),
    .ram_rd_addr(rdAddrB), .ram_rd_data(zeroByte));

  int checks = 0;
  int failures = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected memory contents plus per-cycle expected outputs.
  logic [7:0]    modelMem [0:(1<<AW)-1];
  bit            modelValid = 1'b0;
  logic          eAck = 1'b0, eVidValid = 1'b0, eBusy = 1'b0, eDone = 1'b0, eWrEn = 1'b0;
  logic [7:0]    eRdata = '0, eVidData = '0, eWrData = '0, fillVal = '0, cpuCapture = '0;
  logic [AW-1:0] eWrAddr = '0;
  int            cpuLeft = 0;
  int            fillNext = 0;

  always @(posedge clk) begin
    logic [7:0] rdSnap, vidSnap;
    logic       prevAck, prevBusy, prevDone, fillIdle;
    rdSnap  = modelMem[cpu_addr];
    vidSnap = modelMem[vid_addr];
    if (eWrEn) modelMem[eWrAddr] = eWrData;
    prevAck = eAck; prevBusy = eBusy; prevDone = eDone;
    eAck = 1'b0; eDone = 1'b0; eWrEn = 1'b0;
    eVidValid = vid_rd_en;
    if (vid_rd_en) eVidData = vidSnap;
    if (rst) begin
      modelValid = 1'b1;
      eVidValid = 1'b0; eBusy = 1'b0; eRdata = '0; eWrAddr = '0; eWrData = '0;
      cpuLeft = 0; fillNext = 0;
    end else begin
      fillIdle = !prevBusy && !prevDone;
      if (fillIdle && fill_start) begin
        fillVal = fill_value; eBusy = 1'b1; fillNext = 1;
        eWrEn = 1'b1; eWrAddr = '0; eWrData = fill_value;
      end else if (prevBusy) begin
        if (fillNext == FILL_A) begin
          eBusy = 1'b0; eDone = 1'b1;
        end else begin
          eWrEn = 1'b1; eWrAddr = AW'(fillNext); eWrData = fillVal; fillNext++;
        end
      end
      if (cpuLeft > 0) begin
        cpuLeft--;
        if (cpuLeft == 0) begin eAck = 1'b1; eRdata = cpuCapture; end
      end else if (!prevAck && cpu_req) begin
        if (cpu_we) begin
          if (fillIdle && !fill_start) begin
            eAck = 1'b1; eWrEn = 1'b1; eWrAddr = cpu_addr; eWrData = cpu_wdata;
          end
        end else if (!vid_rd_en) begin
          cpuLeft = 1; cpuCapture = rdSnap;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("cpu_ack", 32'(cpu_ack), 32'(eAck));
      checkOutput("cpu_rdata", 32'(cpu_rdata), 32'(eRdata));
      checkOutput("vid_valid", 32'(vid_valid), 32'(eVidValid));
      checkOutput("fill_busy", 32'(fill_busy), 32'(eBusy));
      checkOutput("fill_done", 32'(fill_done), 32'(eDone));
      checkOutput("ram_wr_en", 32'(ram_wr_en), 32'(eWrEn));
      checkOutput("ram_rd_addr", 32'(ram_rd_addr), 32'(vid_rd_en ? vid_addr : cpu_addr));
      if (eWrEn) begin
        checkOutput("ram_wr_addr", 32'(ram_wr_addr), 32'(eWrAddr));
        checkOutput("ram_wr_data", 32'(ram_wr_data), 32'(eWrData));
      end
      if (eVidValid) checkOutput("vid_rdata", 32'(vid_rdata), 32'(eVidData));
    end
  end

  // Scenario counters, cleared whenever the matching enable is low.
  bit monOn = 1'b0, monBOn = 1'b0;
  int wrCount, busyCount, doneCount, vidCount, seqBad, monNext;
  int wrB, busyB, doneB, seqBadB, nextB;

  always @(negedge clk) begin
    if (!monOn) begin
      wrCount = 0; busyCount = 0; doneCount = 0; vidCount = 0; seqBad = 0; monNext = 0;
    end else begin
      if (ram_wr_en) begin
        if (ram_wr_addr != AW'(monNext)) seqBad++;
        monNext++; wrCount++;
      end
      if (fill_busy) busyCount++;
      if (fill_done) doneCount++;
      if (vid_valid) vidCount++;
    end
    if (!monBOn) begin
      wrB = 0; busyB = 0; doneB = 0; seqBadB = 0; nextB = 0;
    end else begin
      if (wrEnB) begin
        if (wrAddrB != 4'(nextB)) seqBadB++;
        nextB++; wrB++;
      end
      if (fillBusyB) busyB++;
      if (fillDoneB) doneB++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpuAccess(input logic we, input logic [AW-1:0] addr, input logic [7:0] wdata,
                           output int lat, output logic [7:0] rd);
    bit seen = 1'b0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    lat = 0; rd = '0;
    while (!seen && lat < 100) begin
      tick();
      lat++;
      if (cpu_ack) begin seen = 1'b1; rd = cpu_rdata; end
    end
    if (!seen) begin
      checks++; failures++;
      $display("[TB] FAIL cpu_ack_timeout: got no ack required ack within 100 cycles");
    end
    tick();
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] val);
    fill_start = 1'b1; fill_value = val;
    tick();
    fill_start = 1'b0;
  endtask

  task automatic waitDone(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      if (fill_done) seen = 1'b1;
    end
    checkOutput(name, 32'(seen), 32'd1);
  endtask

  task automatic restartMon();
    monOn = 1'b0;
    tick();
    monOn = 1'b1;
  endtask

  initial begin
    int lat;
    logic [7:0] rd;
    bit seen;

    repeat (2) tick();
    checkOutput("reset_cpu_ack", 32'(cpu_ack), 32'd0);
    checkOutput("reset_cpu_rdata", 32'(cpu_rdata), 32'd0);
    checkOutput("reset_fill_busy", 32'(fill_busy), 32'd0);
    checkOutput("reset_fill_done", 32'(fill_done), 32'd0);
    checkOutput("reset_vid_valid", 32'(vid_valid), 32'd0);
    checkOutput("reset_wr_en", 32'(ram_wr_en), 32'd0);
    checkOutput("reset_wr_addr", 32'(ram_wr_addr), 32'd0);
    checkOutput("reset_wr_data", 32'(ram_wr_data), 32'd0);
    rst = 1'b0; rstB = 1'b0;
    tick();

    $display("[TB] CPU write then read of 0x00010");
    cpuAccess(1'b1, AW'(17'h00010), 8'hA5, lat, rd);
    checkOutput("write_latency", 32'(lat), 32'd1);
    cpuAccess(1'b0, AW'(17'h00010), 8'h00, lat, rd);
    checkOutput("read_latency", 32'(lat), 32'd2);
    checkOutput("read_data", 32'(rd), 32'hA5);

    $display("[TB] CPU read held off by 5 cycles of video reads");
    restartMon();
    fork
      begin
        vid_rd_en = 1'b1; vid_addr = AW'(17'h00010);
        repeat (5) tick();
        vid_rd_en = 1'b0;
      end
      cpuAccess(1'b0, AW'(17'h00010), 8'h00, lat, rd);
    join
    repeat (3) tick();
    checkOutput("read_after_vid_latency", 32'(lat), 32'd7);
    checkOutput("read_after_vid_data", 32'(rd), 32'hA5);
    checkOutput("vid_valid_cycles", 32'(vidCount), 32'd5);

    $display("[TB] Fill of 16 words with 0x3C");
    cpuAccess(1'b1, AW'(16), 8'h77, lat, rd);
    restartMon();
    applyStimulus(8'h3C);
    repeat (3) tick();
    applyStimulus(8'h99);
    waitDone("fill1_done_seen");
    repeat (3) tick();
    checkOutput("fill1_writes", 32'(wrCount), 32'd16);
    checkOutput("fill1_busy_cycles", 32'(busyCount), 32'd16);
    checkOutput("fill1_done_pulses", 32'(doneCount), 32'd1);
    checkOutput("fill1_addr_order", 32'(seqBad), 32'd0);
    for (int a = 0; a <= 16; a++) begin
      cpuAccess(1'b0, AW'(a), 8'h00, lat, rd);
      checkOutput($sformatf("fill1_readback_%0d", a), 32'(rd), (a < 16) ? 32'h3C : 32'h77);
    end

    $display("[TB] CPU write colliding with fill_start");
    restartMon();
    fork
      applyStimulus(8'h3C);
      cpuAccess(1'b1, AW'(17'h00020), 8'h5A, lat, rd);
    join
    checkOutput("collide_write_latency", 32'(lat), 32'd19);
    checkOutput("collide_done_pulses", 32'(doneCount), 32'd1);
    checkOutput("collide_writes", 32'(wrCount), 32'd17);
    cpuAccess(1'b0, AW'(17'h00020), 8'h00, lat, rd);
    checkOutput("collide_readback", 32'(rd), 32'h5A);

    $display("[TB] Reset at fill word 7");
    restartMon();
    applyStimulus(8'h22);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (ram_wr_en && fill_busy && ram_wr_addr == AW'(7)) begin
        seen = 1'b1; rst = 1'b1;
      end else tick();
    end
    checkOutput("word7_seen", 32'(seen), 32'd1);
    tick();
    rst = 1'b0;
    checkOutput("abort_wr_en", 32'(ram_wr_en), 32'd0);
    checkOutput("abort_fill_busy", 32'(fill_busy), 32'd0);
    checkOutput("abort_cpu_rdata", 32'(cpu_rdata), 32'd0);
    repeat (20) tick();
    checkOutput("abort_no_done", 32'(doneCount), 32'd0);
    restartMon();
    applyStimulus(8'h44);
    waitDone("refill_done_seen");
    tick();
    checkOutput("refill_writes", 32'(wrCount), 32'd16);
    checkOutput("refill_addr_order", 32'(seqBad), 32'd0);

    $display("[TB] Full-range fill on the 4-bit build");
    monBOn = 1'b1;
    tick();
    fillStartB = 1'b1; fillValueB = 8'hE7;
    tick();
    fillStartB = 1'b0;
    repeat (40) tick();
    checkOutput("full_writes", 32'(wrB), 32'd16);
    checkOutput("full_addr_order", 32'(seqBadB), 32'd0);
    checkOutput("full_busy_cycles", 32'(busyB), 32'd16);
    checkOutput("full_done_pulses", 32'(doneB), 32'd1);
    checkOutput("full_idle_busy", 32'(fillBusyB), 32'd0);
    checkOutput("full_idle_wr_en", 32'(wrEnB), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at t=%0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/playram_arb.md
PLAYRAM_ARB -- requirements
Module: playram_arb

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter ADDR_W, default 17, the playram address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, the playram data width.
REQ-003 The block SHALL have parameter FILL_LEN, default 76800, the number of words written per fill (range 1..2**ADDR_W).

Ports (name, direction, width, meaning):
REQ-004 The block SHALL have the following ports, clock and reset first:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request; the CPU holds it until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; held with cpu_req.
- cpu_addr  in  ADDR_W  CPU address; held with cpu_req.
- cpu_wdata  in  DATA_W  CPU write data; held with cpu_req.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  read data; valid while cpu_ack=1 for a read.
- vid_rd_en  in  1  video scanout read strobe.
- vid_addr  in  ADDR_W  video read address.
- vid_rdata  out  DATA_W  video read data.
- vid_valid  out  1  vid_rdata valid.
- fill_start  in  1  start a screen fill.
- fill_value  in  DATA_W  fill data, sampled at start.
- fill_busy  out  1  fill in progress.
- fill_done  out  1  one-cycle pulse at fill completion.
- ram_wr_en  out  1  playram write enable.
- ram_wr_addr  out  ADDR_W  playram write address.
- ram_wr_data  out  DATA_W  playram write data.
- ram_rd_addr  out  ADDR_W  playram read address.
- ram_rd_data  in  DATA_W  playram read data; valid one cycle after the address is sampled (no output register).

Function
REQ-005 ram_wr_en, ram_wr_addr and ram_wr_data SHALL be registered outputs.
REQ-006 ram_rd_addr SHALL be combinational: vid_addr when vid_rd_en=1, otherwise cpu_addr.
REQ-007 Video reads SHALL have absolute priority on the read port and SHALL never stall.
- vid_valid is vid_rd_en delayed by one cycle.
- vid_rdata is ram_rd_data passed through.
REQ-008 The CPU FSM SHALL have the states C_IDLE, C_RD_WAIT and C_ACK.
REQ-009 CPU write from C_IDLE: when cpu_req=1, cpu_we=1 and the fill FSM is F_IDLE and fill_start=0, then at the next edge:
- ram_wr_en=1 with cpu_addr and cpu_wdata;
- cpu_ack=1;
- the FSM goes to C_ACK.
Write latency is 1 cycle.
REQ-010 CPU read from C_IDLE: when cpu_req=1, cpu_we=0 and vid_rd_en=0, the FSM SHALL go to C_RD_WAIT.
- At the following edge, cpu_rdata is loaded from ram_rd_data, cpu_ack=1, and the FSM goes to C_ACK.
- Read latency is 2 cycles.
REQ-011 A CPU read SHALL wait in C_IDLE while vid_rd_en=1.
- C_RD_WAIT always completes; the address was already sampled.
- A CPU read proceeds while a fill is in progress.
REQ-012 C_ACK SHALL return to C_IDLE unconditionally, so a held cpu_req is not re-accepted in the ack cycle.
REQ-013 cpu_rdata SHALL hold its value until the next CPU read completes.
REQ-014 The fill FSM SHALL have the states F_IDLE, F_RUN and F_DONE.
REQ-015 fill_start=1 in F_IDLE SHALL latch fill_value and go to F_RUN.
- fill_start is ignored in F_RUN and F_DONE.
REQ-016 In F_RUN the block SHALL:
- write fill_value to addresses 0..FILL_LEN-1, one per cycle in ascending order, each with ram_wr_en=1;
- assert fill_busy throughout F_RUN;
- go to F_DONE after address FILL_LEN-1.
REQ-017 F_DONE SHALL last one cycle with fill_done=1 and fill_busy=0, then return to F_IDLE.
REQ-018 Write-port arbitration SHALL be as follows:
- the fill owns the write port from fill_start acceptance through F_RUN;
- a CPU write pending in that window waits in C_IDLE;
- if a CPU write and fill_start are both present in the same cycle, the fill wins;
- a CPU write already issued (C_ACK) is not affected.
REQ-019 The fill address counter SHALL be ADDR_W+1 bits wide so that FILL_LEN=2**ADDR_W terminates without wrap.

Reset
REQ-020 While rst=1 at a clock edge, the block SHALL set both FSMs to idle and all outputs to 0: cpu_ack, cpu_rdata, vid_valid, fill_busy, fill_done, ram_wr_en, ram_wr_addr and ram_wr_data.
REQ-021 Reset during a fill SHALL abort it with no fill_done pulse.
REQ-022 Reset during a CPU access SHALL drop it with no cpu_ack; the CPU re-requests.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- CPU write addr 0x00010, data 0xA5, then CPU read of 0x00010 -> write ack 1 cycle after req; read ack 2 cycles after req with cpu_rdata=0xA5.
- vid_rd_en held for 5 cycles while a CPU read is pending -> CPU read acked exactly 2 cycles after vid_rd_en falls; vid_valid high 5 cycles, one cycle late.
- FILL_LEN=16, fill_value 0x3C -> 16 consecutive writes to 0..15; fill_busy high for 16 cycles; a single fill_done pulse; readback of 0..15 = 0x3C and 16 unchanged.
- CPU write and fill_start in the same cycle (FILL_LEN=16) -> fill runs first; the CPU write is acked in the cycle after F_DONE (FSM back in F_IDLE).
- rst asserted at fill word 7 -> ram_wr_en=0 and fill_busy=0 after the edge; no fill_done pulse; a new fill_start is accepted afterwards.
- FILL_LEN=2**ADDR_W (reduced-width build, ADDR_W=4) -> exactly 16 writes, then termination.
